// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential signed divider.
//   div_state_e : controller states (IDLE, CALC, FIX, DONE)
//   DIV_W       : default divisor / quotient / remainder width
//   QMAX, QMIN  : saturated quotient values at the default width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_W-1:0] QMAX = 16'h7FFF;
  localparam logic [DIV_W-1:0] QMIN = 16'h8000;

endpackage

// File: rtl/div_substep.sv
// -----------------------------------------------------------------------------
// div_substep
// One combinational non-restoring radix-2 division step.
// Ports:
//   i_prem : partial remainder, W+1 bit two's complement
//   i_quo  : quotient shift register; its MSB is the next dividend bit
//   i_dmag : divisor magnitude
//   o_prem : next partial remainder
//   o_quo  : quotient register shifted left with the new quotient bit
// -----------------------------------------------------------------------------
module div_substep #(
  parameter int W = 16
) (
  input  logic [W:0]   i_prem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dmag,
  output logic [W:0]   o_prem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shift;

  // The partial remainder always lies in [-|D|, |D|-1], so its low W bits
  // already carry the sign; shifting them up loses nothing.
  assign w_shift = {i_prem[W-1:0], i_quo[W-1]};

  // Negative remainder: add the divisor back instead of restoring.
  assign o_prem = i_prem[W] ? (w_shift + {1'b0, i_dmag})
                            : (w_shift - {1'b0, i_dmag});

  // A non-negative result means the trial subtraction fit: quotient bit 1.
  assign o_quo = {i_quo[W-2:0], ~o_prem[W]};

endmodule

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
// Iterative signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// and W-bit remainder, one quotient bit per clock (non-restoring radix-2).
// Result truncates toward zero; the remainder takes the dividend's sign.
// Fixed latency: o_valid rises W+1 cycles after the accepting edge.
// Optional macro DIV_ROUND_EN: round the quotient magnitude to nearest
// (half away from zero) while keeping N = Q*D + R.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready       : operand handshake
//   i_dividend, i_divisor   : signed operands
//   o_valid / i_ready       : result handshake
//   o_quotient, o_remainder : signed results, held until accepted
//   o_dbz, o_ovf            : divide-by-zero / quotient overflow flags
// -----------------------------------------------------------------------------
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2*W-1:0]   i_dividend,
  input  logic [W-1:0]     i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_quotient,
  output logic [W-1:0]     o_remainder,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int            CW         = $clog2(W);
  localparam logic [CW-1:0] L_CNT_LAST = CW'(W-1);
  localparam logic [W:0]    L_HALF     = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0]    L_POS_LIM  = {2'b00, {(W-1){1'b1}}};
  localparam logic [W-1:0]  L_QMAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  L_QMIN     = {1'b1, {(W-1){1'b0}}};

  div_state_e     r_state, w_state_next;

  logic           r_sn, r_sd, r_dbz, r_preovf;
  logic [W:0]     r_prem;
  logic [W-1:0]   r_quo, r_dmag;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_quotient, r_remainder;
  logic           r_dbz_out, r_ovf_out;

  logic [2*W-1:0] w_nmag;
  logic [W-1:0]   w_dmag;
  logic [W:0]     w_prem_next;
  logic [W-1:0]   w_quo_next;
  logic [W-1:0]   w_rmag;
  logic [W:0]     w_qmag;
  logic           w_rneg, w_qneg, w_post_ovf;

  // Magnitudes of the most negative operands wrap to themselves, which is the
  // correct unsigned magnitude.
  assign w_nmag = i_dividend[2*W-1] ? -i_dividend : i_dividend;
  assign w_dmag = i_divisor[W-1]    ? -i_divisor  : i_divisor;

  div_substep #(.W(W)) u_substep (
    .i_prem (r_prem),
    .i_quo  (r_quo),
    .i_dmag (r_dmag),
    .o_prem (w_prem_next),
    .o_quo  (w_quo_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_next = CALC;
      end
      CALC: if (r_cnt == L_CNT_LAST) w_state_next = FIX;
      FIX:  w_state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Final correction, optional rounding and post-overflow detection.
  always_comb begin
    w_rmag = r_prem[W] ? (r_prem[W-1:0] + r_dmag) : r_prem[W-1:0];
    w_qmag = {1'b0, r_quo};
    w_rneg = r_sn;
    w_qneg = r_sn ^ r_sd;
`ifdef DIV_ROUND_EN
    if ({w_rmag, 1'b0} >= {1'b0, r_dmag}) begin
      w_qmag = w_qmag + (W+1)'(1);
      w_rmag = r_dmag - w_rmag;
      w_rneg = ~r_sn;
    end
`endif
    // A negative quotient may reach one step further than a positive one.
    w_post_ovf = w_qneg ? (w_qmag > L_HALF) : (w_qmag > L_POS_LIM);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sn        <= 1'b0;
      r_sd        <= 1'b0;
      r_dbz       <= 1'b0;
      r_preovf    <= 1'b0;
      r_prem      <= '0;
      r_quo       <= '0;
      r_dmag      <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz_out   <= 1'b0;
      r_ovf_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_sn     <= i_dividend[2*W-1];
          r_sd     <= i_divisor[W-1];
          r_dmag   <= w_dmag;
          r_dbz    <= (i_divisor == '0);
          // Upper half >= |D| means |Q| >= 2^W: cannot fit, skip checking later.
          r_preovf <= (w_nmag[2*W-1:W] >= w_dmag);
          r_prem   <= {1'b0, w_nmag[2*W-1:W]};
          r_quo    <= w_nmag[W-1:0];
          r_cnt    <= '0;
        end
        CALC: begin
          r_prem <= w_prem_next;
          r_quo  <= w_quo_next;
          r_cnt  <= r_cnt + CW'(1);
        end
        FIX: begin
          if (r_dbz) begin
            r_quotient  <= r_sn ? L_QMIN : L_QMAX;
            r_remainder <= '0;
            r_dbz_out   <= 1'b1;
            r_ovf_out   <= 1'b0;
          end else if (r_preovf || w_post_ovf) begin
            r_quotient  <= w_qneg ? L_QMIN : L_QMAX;
            r_remainder <= '0;
            r_dbz_out   <= 1'b0;
            r_ovf_out   <= 1'b1;
          end else begin
            r_quotient  <= w_qneg ? -w_qmag[W-1:0] : w_qmag[W-1:0];
            r_remainder <= w_rneg ? -w_rmag : w_rmag;
            r_dbz_out   <= 1'b0;
            r_ovf_out   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_dbz       = r_dbz_out;
  assign o_ovf       = r_ovf_out;

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
// Self-checking bench: directed cases with literal results, backpressure,
// mid-operation reset, then randomized operands against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_signed_divider;
  import div_pkg::*;

  localparam int W = DIV_W;

`ifdef DIV_ROUND_EN
  localparam logic [W-1:0] Q_PP = 16'h008F, R_PP = 16'hFFFF;
  localparam logic [W-1:0] Q_NP = 16'hFF71, R_NP = 16'h0001;
  localparam logic [W-1:0] Q_PN = 16'hFF71, R_PN = 16'hFFFF;
  localparam logic [W-1:0] Q_NN = 16'h008F, R_NN = 16'h0001;
`else
  localparam logic [W-1:0] Q_PP = 16'h008E, R_PP = 16'h0006;
  localparam logic [W-1:0] Q_NP = 16'hFF72, R_NP = 16'hFFFA;
  localparam logic [W-1:0] Q_PN = 16'hFF72, R_PN = 16'h0006;
  localparam logic [W-1:0] Q_NN = 16'h008E, R_NN = 16'hFFFA;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [2*W-1:0] i_dividend = '0;
  logic [W-1:0]   i_divisor = '0;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [W-1:0]   o_quotient, o_remainder;
  logic           o_dbz, o_ovf;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  longint accept_cyc = 0;
  bit     lat_armed = 0;
  bit     prev_valid = 0;
  longint cur_n = 0, cur_d = 0;

  seq_signed_divider #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_dbz       (o_dbz),
    .o_ovf       (o_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division truncating toward zero, then limits.
  function automatic res_t model(longint n, longint d);
    res_t   res;
    longint q, rm, lim_hi, lim_lo;
    bit     qneg;
    lim_hi  = (longint'(1) << (W-1)) - 1;
    lim_lo  = -(longint'(1) << (W-1));
    qneg    = (n < 0) != (d < 0);
    res.q   = '0;
    res.r   = '0;
    res.dbz = 1'b0;
    res.ovf = 1'b0;
    if (d == 0) begin
      res.dbz = 1'b1;
      res.q   = (n >= 0) ? QMAX : QMIN;
      return res;
    end
    q  = n / d;
    rm = n - q * d;
`ifdef DIV_ROUND_EN
    if (2 * (rm < 0 ? -rm : rm) >= (d < 0 ? -d : d)) begin
      q  = q + (qneg ? -1 : 1);
      rm = n - q * d;
    end
`endif
    if (q > lim_hi || q < lim_lo) begin
      res.ovf = 1'b1;
      res.q   = qneg ? QMIN : QMAX;
    end else begin
      res.q = q[W-1:0];
      res.r = rm[W-1:0];
    end
    return res;
  endfunction

  // One clock: compare at the falling edge, then advance to just after the
  // rising edge where new stimulus is applied.
  task automatic tick();
    bit   acc;
    res_t e;
    acc = 0;
    @(negedge clk);
    if (rst_n) begin
      chk("o_ready", 64'(o_ready), 64'(exp_q.size() == 0));
      acc = i_valid && (exp_q.size() == 0);
      if (o_valid) begin
        if (lat_armed && !prev_valid) begin
          chk("latency", 64'(cyc - accept_cyc), 64'(W + 1));
          lat_armed = 0;
        end
        if (exp_q.size() == 0) begin
          chk("spurious_o_valid", 64'(o_valid), 64'(0));
        end else begin
          e = exp_q[0];
          chk("quotient",  64'(o_quotient),  64'(e.q));
          chk("remainder", 64'(o_remainder), 64'(e.r));
          chk("dbz",       64'(o_dbz),       64'(e.dbz));
          chk("ovf",       64'(o_ovf),       64'(e.ovf));
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = o_valid;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(model(cur_n, cur_d));
      accept_cyc = cyc;
      lat_armed  = 1;
    end
  endtask

  task automatic run_op(longint n, longint d, int hold, bit lit_en,
                        logic [W-1:0] lq, logic [W-1:0] lr, logic ldbz, logic lovf);
    int k;
    cur_n      = n;
    cur_d      = d;
    i_dividend = n[2*W-1:0];
    i_divisor  = d[W-1:0];
    i_valid    = 1'b1;
    i_ready    = 1'b0;
    tick();
    i_valid = 1'b0;
    k = 0;
    while (o_valid !== 1'b1 && k < 3 * W) begin
      tick();
      k++;
    end
    if (o_valid !== 1'b1) begin
      chk("timeout_o_valid", 64'(o_valid), 64'(1));
      exp_q.delete();
      return;
    end
    if (lit_en) begin
      chk("lit_quotient",  64'(o_quotient),  64'(lq));
      chk("lit_remainder", 64'(o_remainder), 64'(lr));
      chk("lit_dbz",       64'(o_dbz),       64'(ldbz));
      chk("lit_ovf",       64'(o_ovf),       64'(lovf));
    end
    $display("div %0d / %0d -> q=%h r=%h dbz=%0b ovf=%0b hold=%0d",
             n, d, o_quotient, o_remainder, o_dbz, o_ovf, hold);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        // Operands offered while busy must be ignored.
        i_valid    = 1'b1;
        i_dividend = $urandom;
        i_divisor  = 16'($urandom);
      end
      tick();
      i_valid = 1'b0;
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_o_valid"},     64'(o_valid),     64'(0));
    chk({tag, "_o_ready"},     64'(o_ready),     64'(1));
    chk({tag, "_o_quotient"},  64'(o_quotient),  64'(0));
    chk({tag, "_o_remainder"}, 64'(o_remainder), 64'(0));
    chk({tag, "_o_dbz"},       64'(o_dbz),       64'(0));
    chk({tag, "_o_ovf"},       64'(o_ovf),       64'(0));
  endtask

  initial begin
    res_t         m;
    longint       n, d;
    logic [31:0]  u;
    logic [15:0]  v;

    // Pin the model itself against hand-computed results.
    m = model(1000, 7);
    chk("model_1000_7_q", 64'(m.q), 64'(Q_PP));
    chk("model_1000_7_r", 64'(m.r), 64'(R_PP));
    m = model(-32768, 1);
    chk("model_min_q",   64'(m.q),   64'(16'h8000));
    chk("model_min_ovf", 64'(m.ovf), 64'(0));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_op(1000, 7, 0, 1, Q_PP, R_PP, 1'b0, 1'b0);
    run_op(-1000, 7, 0, 1, Q_NP, R_NP, 1'b0, 1'b0);
    run_op(1000, -7, 0, 1, Q_PN, R_PN, 1'b0, 1'b0);
    run_op(-1000, -7, 0, 1, Q_NN, R_NN, 1'b0, 1'b0);
    run_op(5, 0, 0, 1, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run_op(-5, 0, 0, 1, 16'h8000, 16'h0000, 1'b1, 1'b0);
    run_op(32'h7FFF0000, 2, 0, 1, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
    run_op(32768, 1, 0, 1, 16'h7FFF, 16'h0000, 1'b0, 1'b1);

    // Backpressure: result held five cycles with an ignored operand pulse.
    run_op(1000, 7, 5, 1, Q_PP, R_PP, 1'b0, 1'b0);
    tick();

    // Leaves 0x8000 on o_quotient so the reset clearing below is visible.
    run_op(-32768, 1, 0, 1, 16'h8000, 16'h0000, 1'b0, 1'b0);

    // Reset on the 8th CALC cycle of an in-flight 1000 / 7.
    cur_n      = 1000;
    cur_d      = 7;
    i_dividend = 32'd1000;
    i_divisor  = 16'd7;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    lat_armed  = 0;
    prev_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_op(1000, 7, 0, 1, Q_PP, R_PP, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      u = $urandom;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       n = longint'($signed(u));
        1:       n = longint'($signed(u)) >>> $urandom_range(8, 20);
        default: n = longint'($signed(u)) >>> 16;
      endcase
      d = longint'($signed(v));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0:       d = 0;
          1:       d = 1;
          2:       d = -1;
          3:       d = -32768;
          default: d = 32767;
        endcase
      end
      run_op(n, d, $urandom_range(0, 3), 0, '0, '0, 1'b0, 1'b0);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
